fft_bitrev_reorder: RTL and testbench

//  Output reorder buffer for the radix-2^2 SDF FFT.
//  The FFT emits each N-point frame in bit-reversed bin order, already scaled 1/N.

---
 rtl/fft_bitrev_reorder_if.sv | 25 ++
 rtl/fft_bitrev_reorder.sv | 140 ++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_if.sv
// Streaming sample bus around the FFT bit-reversal reorder buffer.
// The input half carries bit-reversed samples from the FFT core; the output
// half carries the same samples re-emitted in natural bin order.
interface fft_bitrev_reorder_if #(
  parameter int WIDTH = 16
);
  logic             idata_en;
  logic [WIDTH-1:0] idata_r;
  logic [WIDTH-1:0] idata_i;
  logic             odata_en;
  logic [WIDTH-1:0] odata_r;
  logic [WIDTH-1:0] odata_i;

  // Upstream/downstream side: feeds FFT samples in, consumes reordered samples.
  modport master (
    output idata_en, idata_r, idata_i,
    input  odata_en, odata_r, odata_i
  );

  // Reorder buffer side.
  modport slave (
    input  idata_en, idata_r, idata_i,
    output odata_en, odata_r, odata_i
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong output reorder buffer for a radix-2^2 SDF FFT.
// Frames arrive in bit-reversed bin order; each is written into one bank at
// its bit-reversed address, then read back linearly from that bank while the
// next frame fills the other bank, giving gap-free natural-order output.
module fft_bitrev_reorder #(
  parameter int N     = 128,
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  fft_bitrev_reorder_if.slave  bus
);

  localparam int LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // Reverse the bit order of an in-frame sample index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

  // Two banks stacked in one array; the top address bit selects the bank.
  logic [2*WIDTH-1:0] mem [2*N];

  logic [LOG2N-1:0] wcnt_q,  wcnt_d;
  logic             wbank_q, wbank_d;
  logic             frame_done;

  logic [0:0]       state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [LOG2N-1:0] raddr_q, raddr_d;

  logic             odata_en_q, odata_en_d;
  logic [WIDTH-1:0] odata_r_q,  odata_r_d;
  logic [WIDTH-1:0] odata_i_q,  odata_i_d;

  logic [2*WIDTH-1:0] rd_word;

  // Write side: count accepted samples and flag the last sample of each frame.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    wcnt_d     = wcnt_q;
    wbank_d    = wbank_q;
    frame_done = 1'b0;
    if (bus.idata_en) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LAST_IDX) begin
        wbank_d    = ~wbank_q;
        frame_done = 1'b1;
      end
    end
  end

  // Store each sample at its natural-order slot in the current write bank.
  always_ff @(posedge clock) begin
    // NOTE: the sample store has no reset branch; its contents are don't-care until a full frame is written, and leaving it unreset keeps it mappable onto block RAM.
    if (bus.idata_en) begin
      mem[{wbank_q, bitrev(wcnt_q)}] <= {bus.idata_r, bus.idata_i};
    end
  end

  // Read FSM: sweep a filled bank linearly, chaining straight into the next
  // bank when it completes on the final read cycle.
  always_comb begin
    state_d = state_q;
    rbank_d = rbank_q;
    raddr_d = raddr_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_done) begin
          state_d = ST_READ;
          rbank_d = wbank_q;
          raddr_d = '0;
        end
      end
      ST_READ: begin
        raddr_d = raddr_q + 1'b1;
        if (raddr_q == LAST_IDX) begin
          if (frame_done) begin
            rbank_d = wbank_q;
            raddr_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output stage: read word for the issued address, zero when nothing is valid.
  always_comb begin
    rd_word    = mem[{rbank_q, raddr_q}];
    odata_en_d = (state_q == ST_READ);
    odata_r_d  = '0;
    odata_i_d  = '0;
    if (odata_en_d) begin
      odata_r_d = rd_word[2*WIDTH-1:WIDTH];
      odata_i_d = rd_word[WIDTH-1:0];
    end
  end

  // State registers; reset abandons any partial frame or readout at once.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: flops use non-blocking assignments so every register samples the pre-edge values of the others.
    if (reset) begin
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      state_q    <= ST_IDLE;
      rbank_q    <= 1'b0;
      raddr_q    <= '0;
      odata_en_q <= 1'b0;
      odata_r_q  <= '0;
      odata_i_q  <= '0;
    end else begin
      wcnt_q     <= wcnt_d;
      wbank_q    <= wbank_d;
      state_q    <= state_d;
      rbank_q    <= rbank_d;
      raddr_q    <= raddr_d;
      odata_en_q <= odata_en_d;
      odata_r_q  <= odata_r_d;
      odata_i_q  <= odata_i_d;
    end
  end

  assign bus.odata_en = odata_en_q;
  assign bus.odata_r  = odata_r_q;
  assign bus.odata_i  = odata_i_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for the FFT bit-reversal reorder buffer.
// A frame-level model places sample k at bin bitrev(k) and schedules the
// finished frame for output two cycles after its last sample.
module tb_fft_bitrev_reorder;

  localparam int N     = 128;
  localparam int LOG2N = 7;
  localparam int WIDTH = 16;
  localparam int MAXC  = 1024;
  localparam int PER   = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #(PER/2) clock = ~clock;

  fft_bitrev_reorder_if #(.WIDTH(WIDTH)) bus ();

  fft_bitrev_reorder #(.N(N), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit               stim_en [MAXC];
  logic [WIDTH-1:0] stim_r  [MAXC];
  logic [WIDTH-1:0] stim_i  [MAXC];
  logic             obs_en  [MAXC];
  logic [WIDTH-1:0] obs_r   [MAXC];
  logic [WIDTH-1:0] obs_i   [MAXC];
  bit               exp_en  [MAXC];
  logic [WIDTH-1:0] exp_r   [MAXC];
  logic [WIDTH-1:0] exp_i   [MAXC];

  function automatic int bitrev(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic void clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      stim_en[c] = 1'b0;
      stim_r[c]  = '0;
      stim_i[c]  = '0;
    end
  endfunction

  // Reference: gather each completed frame in natural order, then expect it
  // on the output in cycles L+2 .. L+N+1 where L is its last input cycle.
  function automatic void build_model();
    logic [WIDTH-1:0] nat_r [N];
    logic [WIDTH-1:0] nat_i [N];
    int k = 0;
    for (int c = 0; c < MAXC; c++) begin
      exp_en[c] = 1'b0;
      exp_r[c]  = '0;
      exp_i[c]  = '0;
    end
    for (int c = 0; c < MAXC; c++) begin
      if (stim_en[c]) begin
        nat_r[bitrev(k)] = stim_r[c];
        nat_i[bitrev(k)] = stim_i[c];
        k++;
        if (k == N) begin
          for (int j = 0; j < N; j++) begin
            if (c + 2 + j < MAXC) begin
              exp_en[c+2+j] = 1'b1;
              exp_r[c+2+j]  = nat_r[j];
              exp_i[c+2+j]  = nat_i[j];
            end
          end
          k = 0;
        end
      end
    end
  endfunction

  // One cycle: drive inputs just after the edge, sample outputs mid-cycle.
  task automatic drive_cycle(input int c);
    bus.idata_en = stim_en[c];
    bus.idata_r  = stim_r[c];
    bus.idata_i  = stim_i[c];
    @(negedge clock);
    obs_en[c] = bus.odata_en;
    obs_r[c]  = bus.odata_r;
    obs_i[c]  = bus.odata_i;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int t_total);
    for (int c = 0; c < t_total; c++) begin
      drive_cycle(c);
    end
    bus.idata_en = 1'b0;
    bus.idata_r  = '0;
    bus.idata_i  = '0;
  endtask

  // Mid-cycle reset pulse spanning one clock edge; returns just after an edge.
  task automatic reset_pulse();
    bus.idata_en = 1'b0;
    #3 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.idata_en = 1'b0;
    bus.idata_r  = '0;
    bus.idata_i  = '0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.odata_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_en: got %b want 0", bus.odata_en);
    end
    checks++;
    if (bus.odata_r !== '0) begin
      failures++;
      $display("FAIL reset_r: got %0h want 0", bus.odata_r);
    end
    checks++;
    if (bus.odata_i !== '0) begin
      failures++;
      $display("FAIL reset_i: got %0h want 0", bus.odata_i);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_single_frame();
    int t = 2 * N + 6;
    clear_stim();
    for (int k = 0; k < N; k++) begin
      stim_en[k] = 1'b1;
      stim_r[k]  = WIDTH'(bitrev(k));
      stim_i[k]  = WIDTH'(k);
    end
    build_model();
    run(t);
    for (int c = 0; c < t; c++) begin
      checks++;
      if (obs_en[c] !== exp_en[c] || obs_r[c] !== exp_r[c] || obs_i[c] !== exp_i[c]) begin
        failures++;
        $display("FAIL single_frame cyc %0d: got en=%b r=%0d i=%0d want en=%b r=%0d i=%0d",
                 c, obs_en[c], obs_r[c], obs_i[c], exp_en[c], exp_r[c], exp_i[c]);
      end
    end
    checks++;
    if (obs_en[128] !== 1'b0) begin
      failures++;
      $display("FAIL single_frame_early: cyc 128 en=%b want 0", obs_en[128]);
    end
    checks++;
    if (obs_en[129] !== 1'b1 || obs_r[129] !== 16'd0) begin
      failures++;
      $display("FAIL single_frame_first: cyc 129 en=%b r=%0d want en=1 r=0", obs_en[129], obs_r[129]);
    end
    checks++;
    if (obs_i[130] !== 16'd64) begin
      failures++;
      $display("FAIL single_frame_bin1: cyc 130 i=%0d want 64", obs_i[130]);
    end
    checks++;
    if (obs_en[256] !== 1'b1 || obs_en[257] !== 1'b0) begin
      failures++;
      $display("FAIL single_frame_end: en[256]=%b en[257]=%b want 1,0", obs_en[256], obs_en[257]);
    end
  endtask

  task automatic test_back_to_back();
    int t = 4 * N + 6;
    int run_len = 0;
    reset_pulse();
    clear_stim();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        stim_en[f*N+k] = 1'b1;
        stim_r[f*N+k]  = WIDTH'(f * 256 + bitrev(k));
        stim_i[f*N+k]  = WIDTH'($urandom);
      end
    end
    build_model();
    run(t);
    for (int c = 0; c < t; c++) begin
      checks++;
      if (obs_en[c] !== exp_en[c] || obs_r[c] !== exp_r[c] || obs_i[c] !== exp_i[c]) begin
        failures++;
        $display("FAIL back_to_back cyc %0d: got en=%b r=%0d i=%0d want en=%b r=%0d i=%0d",
                 c, obs_en[c], obs_r[c], obs_i[c], exp_en[c], exp_r[c], exp_i[c]);
      end
    end
    while (129 + run_len < t && obs_en[129+run_len] === 1'b1) run_len++;
    checks++;
    if (run_len != 3 * N || obs_en[128] !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_run: run from 129 = %0d (en[128]=%b) want 384 (en[128]=0)", run_len, obs_en[128]);
    end
  endtask

  task automatic test_gapped();
    int t = 2 * N + N + 6;
    int first = -1;
    int cnt = 0;
    reset_pulse();
    clear_stim();
    for (int k = 0; k < N; k++) begin
      stim_en[2*k] = 1'b1;
      stim_r[2*k]  = WIDTH'($urandom);
      stim_i[2*k]  = WIDTH'($urandom);
    end
    build_model();
    run(t);
    for (int c = 0; c < t; c++) begin
      checks++;
      if (obs_en[c] !== exp_en[c] || obs_r[c] !== exp_r[c] || obs_i[c] !== exp_i[c]) begin
        failures++;
        $display("FAIL gapped cyc %0d: got en=%b r=%0h i=%0h want en=%b r=%0h i=%0h",
                 c, obs_en[c], obs_r[c], obs_i[c], exp_en[c], exp_r[c], exp_i[c]);
      end
      if (obs_en[c] === 1'b1) begin
        if (first < 0) first = c;
        cnt++;
      end
    end
    checks++;
    if (first != 256 || cnt != N) begin
      failures++;
      $display("FAIL gapped_window: first=%0d count=%0d want first=256 count=128", first, cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t = 2 * N + 6;
    int first = -1;
    reset_pulse();
    clear_stim();
    for (int c = 0; c < 60; c++) begin
      stim_en[c] = 1'b1;
      stim_r[c]  = WIDTH'($urandom);
      stim_i[c]  = WIDTH'($urandom);
    end
    run(62);
    for (int c = 0; c < 62; c++) begin
      checks++;
      if (obs_en[c] !== 1'b0) begin
        failures++;
        $display("FAIL partial_frame cyc %0d: en=%b want 0", c, obs_en[c]);
      end
    end
    reset_pulse();
    clear_stim();
    for (int k = 0; k < N; k++) begin
      stim_en[k] = 1'b1;
      stim_r[k]  = WIDTH'($urandom);
      stim_i[k]  = WIDTH'($urandom);
    end
    build_model();
    run(t);
    for (int c = 0; c < t; c++) begin
      checks++;
      if (obs_en[c] !== exp_en[c] || obs_r[c] !== exp_r[c] || obs_i[c] !== exp_i[c]) begin
        failures++;
        $display("FAIL after_partial cyc %0d: got en=%b r=%0h i=%0h want en=%b r=%0h i=%0h",
                 c, obs_en[c], obs_r[c], obs_i[c], exp_en[c], exp_r[c], exp_i[c]);
      end
      if (first < 0 && obs_en[c] === 1'b1) first = c;
    end
    checks++;
    if (first != 129) begin
      failures++;
      $display("FAIL after_partial_latency: first output cyc %0d want 129", first);
    end
  endtask

  task automatic test_reset_readout();
    reset_pulse();
    clear_stim();
    for (int k = 0; k < N; k++) begin
      stim_en[k] = 1'b1;
      stim_r[k]  = WIDTH'($urandom);
      stim_i[k]  = WIDTH'($urandom);
    end
    build_model();
    run(169);
    // Cycle 169 carries bin 40; reset lands mid-cycle right after it is seen.
    @(negedge clock);
    checks++;
    if (bus.odata_en !== 1'b1 || bus.odata_r !== exp_r[169] || bus.odata_i !== exp_i[169]) begin
      failures++;
      $display("FAIL readout_bin40: got en=%b r=%0h i=%0h want en=1 r=%0h i=%0h",
               bus.odata_en, bus.odata_r, bus.odata_i, exp_r[169], exp_i[169]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.odata_en !== 1'b0 || bus.odata_r !== '0 || bus.odata_i !== '0) begin
      failures++;
      $display("FAIL readout_async_reset: got en=%b r=%0h i=%0h want 0 0 0",
               bus.odata_en, bus.odata_r, bus.odata_i);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clock);
      checks++;
      if (bus.odata_en !== 1'b0) begin
        failures++;
        $display("FAIL readout_abandoned cyc %0d after reset: en=%b want 0", c, bus.odata_en);
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_reset_mid_frame();
    test_reset_readout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case any wait above never returns.
  initial begin
    #(PER * 20000);
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

endmodule
